// File: rtl/frame_buf_writer.sv
// Packs the camera byte stream into little-endian 32-bit words and writes one armed frame to SPRAM.
// Optional macro FRAME_CHECKSUM_EN adds a mod-2^32 sum of accepted words on the checksum output.
module frame_buf_writer #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 4800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sof,
    input  logic              i_eof,
    input  logic [7:0]        i_dat,
    input  logic              i_vld,
    input  logic              arm,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W:0]   words_written,
    output logic              overflow,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + MAX_WORDS - 1);
    localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_next;
    logic [31:0]       asm_q, asm_next;
    logic              pend_q;
    logic [31:0]       pend_word_q;
    logic [31:0]       fifo_mem [2];
    logic              fifo_wr_q, fifo_rd_q;
    logic [1:0]        fifo_cnt_q;
    logic [ADDR_W:0]   push_cnt_q, acc_cnt_q, words_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ovf_q, done_q;

    logic start, flush_done, cap_en, arm_ok;
    logic word_full, word_part;
    logic pop, push, drop, room;

    // NOTE: state register uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            IDLE:     if (arm) state_d = WAIT_SOF;
            WAIT_SOF: if (i_sof) begin
                          state_d = CAPTURE;
                          start   = 1'b1;
                      end
            CAPTURE:  if (i_eof) state_d = FLUSH;
            FLUSH:    if (!pend_q && fifo_cnt_q == 2'd0) begin
                          state_d    = IDLE;
                          flush_done = 1'b1;
                      end
            default:  state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            start      = 1'b0;
            flush_done = 1'b0;
        end
    end

    // Byte merge: lane 0 starts a fresh word so unwritten upper lanes read as zero.
    always_comb begin
        asm_next  = asm_q;
        lane_next = lane_q;
        if (i_vld) begin
            if (lane_q == 2'd0) asm_next = {24'h0, i_dat};
            else                asm_next[{lane_q, 3'b000} +: 8] = i_dat;
            lane_next = lane_q + 2'd1;
        end
    end

    assign cap_en    = (state_q == CAPTURE) && !abort;
    assign arm_ok    = (state_q == IDLE) && arm && !abort;
    assign word_full = i_vld && (lane_q == 2'd3);
    assign word_part = i_eof && (lane_next != 2'd0);

    assign mem_we    = (fifo_cnt_q != 2'd0) && !abort;
    assign pop       = mem_we && mem_ready;
    assign room      = (fifo_cnt_q != 2'd2) || pop;
    assign push      = pend_q && !abort && (push_cnt_q < CAP) && room;
    assign drop      = pend_q && !abort && !((push_cnt_q < CAP) && room);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q      <= 2'd0;
            asm_q       <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_rd_q   <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            push_cnt_q  <= '0;
            acc_cnt_q   <= '0;
            words_q     <= '0;
            addr_q      <= BASE;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= flush_done;
            pend_q      <= cap_en && (word_full || word_part);
            pend_word_q <= asm_next;
            if (flush_done) words_q <= acc_cnt_q;
            if (cap_en) begin
                asm_q  <= asm_next;
                lane_q <= lane_next;
            end
            if (arm_ok)    ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
            if (start) begin
                lane_q     <= 2'd0;
                push_cnt_q <= '0;
                acc_cnt_q  <= '0;
                addr_q     <= BASE;
            end else begin
                if (push) push_cnt_q <= push_cnt_q + ONE;
                if (pop) begin
                    acc_cnt_q <= acc_cnt_q + ONE;
                    if (addr_q < LAST) addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (abort) begin
                fifo_wr_q  <= 1'b0;
                fifo_rd_q  <= 1'b0;
                fifo_cnt_q <= 2'd0;
            end else begin
                if (push) fifo_wr_q <= ~fifo_wr_q;
                if (pop)  fifo_rd_q <= ~fifo_rd_q;
                fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
            end
        end
    end

    // NOTE: FIFO storage has no reset; fifo_cnt_q qualifies every read of it.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wr_q] <= pend_word_q;
    end

    assign mem_wdata     = (fifo_cnt_q != 2'd0) ? fifo_mem[fifo_rd_q] : 32'h0;
    assign mem_addr      = addr_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = done_q;
    assign words_written = words_q;
    assign overflow      = ovf_q;

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] sum_q, cks_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            cks_q <= '0;
        end else begin
            if (start)    sum_q <= '0;
            else if (pop) sum_q <= sum_q + mem_wdata;
            if (flush_done) cks_q <= sum_q;
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_frame_buf_writer.sv
// Self-checking bench for frame_buf_writer: queue-based reference model compared every cycle,
// directed test-plan frames with literal expectations, then randomized frames.
module tb_frame_buf_writer;

    localparam int ADDR_W = 14;
    localparam int BASE   = 10;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_sof, i_eof, i_vld, arm, abort, mem_ready;
    logic [7:0]        i_dat;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, checksum;
    logic              mem_we, busy, frame_done, overflow;
    logic [ADDR_W:0]   words_written;

    always #5 clk = ~clk;

    frame_buf_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .i_sof(i_sof), .i_eof(i_eof), .i_dat(i_dat), .i_vld(i_vld),
        .arm(arm), .abort(abort), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done),
        .words_written(words_written), .overflow(overflow), .checksum(checksum)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for sof, 2 capturing, 3 flushing.
    int          m_phase, m_lane, m_pushed, m_acc, m_addr, m_ww;
    bit          m_pend, m_ovf, m_done;
    logic [31:0] m_word, m_pend_word, m_sum, m_cks;
    logic [31:0] m_fifo [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_lane = 0; m_pushed = 0; m_acc = 0; m_addr = BASE; m_ww = 0;
            m_pend = 0; m_ovf = 0; m_done = 0; m_word = 0; m_pend_word = 0; m_sum = 0; m_cks = 0;
            m_fifo.delete();
        end else begin
            bit pop, flush_ok;
            flush_ok = (m_phase == 3) && !m_pend && (m_fifo.size() == 0);
            pop      = (m_fifo.size() != 0) && !abort && mem_ready;
            m_done   = 0;
            if (abort) begin
                m_phase = 0;
                m_pend  = 0;
                m_fifo.delete();
            end else begin
                if (pop) begin
                    m_sum = m_sum + m_fifo[0];
                    void'(m_fifo.pop_front());
                    m_acc++;
                    if (m_addr < BASE + MAXW - 1) m_addr++;
                end
                if (m_pend) begin
                    if (m_pushed >= MAXW || m_fifo.size() >= 2) m_ovf = 1;
                    else begin
                        m_fifo.push_back(m_pend_word);
                        m_pushed++;
                    end
                end
                m_pend = 0;
                case (m_phase)
                    0: if (arm) begin m_phase = 1; m_ovf = 0; end
                    1: if (i_sof) begin
                           m_phase = 2; m_lane = 0; m_word = 0; m_pushed = 0;
                           m_acc = 0; m_addr = BASE; m_sum = 0;
                       end
                    2: begin
                           if (i_vld) begin
                               m_word = m_word | (32'(i_dat) << (8 * m_lane));
                               m_lane++;
                               if (m_lane == 4) begin
                                   m_pend = 1; m_pend_word = m_word; m_word = 0; m_lane = 0;
                               end
                           end
                           if (i_eof) begin
                               if (m_lane != 0) begin
                                   m_pend = 1; m_pend_word = m_word; m_word = 0; m_lane = 0;
                               end
                               m_phase = 3;
                           end
                       end
                    default: if (flush_ok) begin
                           m_ww = m_acc; m_cks = m_sum; m_done = 1; m_phase = 0;
                       end
                endcase
            end
        end
    end

    // Compare process plus a log of the writes the DUT actually performed.
    int          log_addr [$];
    logic [31:0] log_data [$];
    int          n_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("mem_we", mem_we, (m_fifo.size() != 0) && !abort);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
            check("busy", busy, m_phase != 0);
            check("frame_done", frame_done, m_done);
            check("words_written", words_written, m_ww);
            check("overflow", overflow, m_ovf);
`ifdef FRAME_CHECKSUM_EN
            check("checksum", checksum, m_cks);
`else
            check("checksum", checksum, 0);
`endif
            if (mem_we && mem_ready) begin
                log_addr.push_back(int'(mem_addr));
                log_data.push_back(mem_wdata);
            end
            if (frame_done) n_done++;
        end
    end

    int rdy_mode = 1;  // 0 stall, 1 always ready, 2 random
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       mem_ready = 1'b0;
                1:       mem_ready = 1'b1;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_arm();   arm = 1'b1;   cyc(); arm = 1'b0;   endtask
    task automatic pulse_sof();   i_sof = 1'b1; cyc(); i_sof = 1'b0; endtask
    task automatic pulse_eof();   i_eof = 1'b1; cyc(); i_eof = 1'b0; endtask
    task automatic pulse_abort(); abort = 1'b1; cyc(); abort = 1'b0; endtask

    task automatic send(input logic [7:0] b, input bit with_eof, input int gap);
        i_vld = 1'b1; i_dat = b; i_eof = with_eof;
        cyc();
        i_vld = 1'b0; i_eof = 1'b0;
        cyc(gap);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin cyc(); n++; end
        check({"idle timeout ", name}, busy, 0);
        cyc(2);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        int done0;
        logic [31:0] held;
        rst = 1'b1; i_sof = 0; i_eof = 0; i_vld = 0; i_dat = 0; arm = 0; abort = 0;
        cyc(3);
        check("reset mem_addr", mem_addr, BASE);
        check("reset mem_we", mem_we, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        check("reset words_written", words_written, 0);
        rst = 1'b0;
        cyc(2);

        // 8 bytes 01..08
        clear_log(); done0 = n_done; rdy_mode = 1;
        pulse_arm(); cyc(); pulse_sof();
        for (int i = 1; i <= 8; i++) send(8'(i), 0, 1);
        pulse_eof(); wait_idle("t1");
        check("t1 write count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t1 addr0", log_addr[0], BASE);
            check("t1 data0", log_data[0], 32'h04030201);
            check("t1 addr1", log_addr[1], BASE + 1);
            check("t1 data1", log_data[1], 32'h08070605);
        end
        check("t1 frame_done pulses", n_done - done0, 1);
        check("t1 words_written", words_written, 2);
        check("t1 overflow", overflow, 0);
`ifdef FRAME_CHECKSUM_EN
        check("t1 checksum", checksum, 32'h0C0A0806);
`else
        check("t1 checksum", checksum, 0);
`endif

        // 6 bytes A0..A5: zero-padded partial word
        clear_log();
        pulse_arm(); pulse_sof();
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 0, 0);
        pulse_eof(); wait_idle("t2");
        check("t2 write count", log_addr.size(), 2);
        if (log_data.size() == 2) begin
            check("t2 data0", log_data[0], 32'hA3A2A1A0);
            check("t2 data1", log_data[1], 32'h0000A5A4);
        end
        check("t2 words_written", words_written, 2);

        // RAM stalled while 16 bytes stream at 1 byte per 4 clk
        clear_log(); rdy_mode = 0;
        pulse_arm(); pulse_sof();
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 0, 3);
        pulse_eof(); cyc(2);
        held = mem_wdata;
        check("t3 stalled we", mem_we, 1);
        check("t3 stalled addr", mem_addr, BASE);
        check("t3 stalled data", held, 32'h13121110);
        check("t3 overflow", overflow, 1);
        cyc(10);
        check("t3 data stable", mem_wdata, held);
        check("t3 no writes while stalled", log_addr.size(), 0);
        rdy_mode = 1; wait_idle("t3");
        check("t3 write count", log_addr.size(), 2);
        if (log_data.size() == 2) check("t3 data1", log_data[1], 32'h17161514);
        check("t3 words_written", words_written, 2);

        // 24 bytes against a 4-word capacity
        clear_log();
        pulse_arm(); pulse_sof();
        for (int i = 0; i < 24; i++) send(8'h30 + 8'(i), 0, 0);
        pulse_eof(); wait_idle("t4");
        check("t4 write count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            check("t4 addr3", log_addr[3], BASE + 3);
            check("t4 data3", log_data[3], 32'h3F3E3D3C);
        end
        check("t4 words_written", words_written, 4);
        check("t4 overflow", overflow, 1);
        check("t4 mem_addr capped", mem_addr, BASE + 3);

        // abort mid-capture, then re-arm
        clear_log(); done0 = n_done; rdy_mode = 0;
        pulse_arm(); pulse_sof();
        for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 0, 0);
        pulse_abort();
        check("t5 mem_we after abort", mem_we, 0);
        check("t5 busy after abort", busy, 0);
        rdy_mode = 1; cyc(5);
        check("t5 no frame_done", n_done - done0, 0);
        check("t5 words_written kept", words_written, 4);
        check("t5 no writes", log_addr.size(), 0);
        pulse_arm(); pulse_sof();
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 0, 0);
        pulse_eof(); wait_idle("t5");
        check("t5 rearm count", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check("t5 rearm addr", log_addr[0], BASE);
            check("t5 rearm data", log_data[0], 32'hC3C2C1C0);
        end
        check("t5 overflow cleared", overflow, 0);

        // unarmed frame, then a second sof during capture
        clear_log();
        pulse_sof();
        for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i), 0, 0);
        pulse_eof(); cyc(5);
        check("t6 unarmed writes", log_addr.size(), 0);
        check("t6 unarmed busy", busy, 0);
        pulse_arm(); pulse_sof();
        for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), 0, 0);
        pulse_sof();
        for (int i = 4; i < 8; i++) send(8'hD0 + 8'(i), 0, 0);
        pulse_eof(); wait_idle("t6");
        check("t6 write count", log_addr.size(), 2);
        if (log_data.size() == 2) check("t6 data1", log_data[1], 32'hD7D6D5D4);
        check("t6 words_written", words_written, 2);

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            int n;
            bit aborted, eof_sent;
            rdy_mode = $urandom_range(1, 2);
            aborted = 0; eof_sent = 0;
            pulse_arm(); cyc($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) send(8'($urandom), $urandom_range(0, 1) == 1, 0);
            pulse_sof();
            n = $urandom_range(1, 28);
            for (int i = 0; i < n && !aborted; i++) begin
                arm   = ($urandom_range(0, 15) == 0);
                i_sof = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 60) == 0) begin
                    arm = 0; i_sof = 0;
                    pulse_abort();
                    aborted = 1;
                end else begin
                    eof_sent = (i == n - 1) && ($urandom_range(0, 1) == 1);
                    send(8'($urandom), eof_sent, 0);
                    arm = 0; i_sof = 0;
                    cyc($urandom_range(0, 4));
                end
            end
            if (!aborted && !eof_sent) pulse_eof();
            if (!aborted && $urandom_range(0, 9) == 0) pulse_abort();
            wait_idle("random");
        end
        rdy_mode = 1; cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_buf_writer.md
Name: frame_buf_writer

Overview:
- Sits directly downstream of the camera interface stage and consumes its byte-wide pixel stream (sof/eof/data/valid).
- Packs four pixels into little-endian 32-bit words and writes them to the frame-buffer RAM (SPRAM) through a valid/ready write port, starting at a configurable base address.
- Capture is single-shot: the CPU arms it, one whole frame is stored, then frame_done pulses and status is latched.
- A 2-entry word FIFO absorbs RAM back-pressure; words that cannot be stored set a sticky overflow flag.

Parameters:
ADDR_W, 14, RAM word-address width (32-bit words)
BASE_ADDR, 0, word address of the first word of a frame
MAX_WORDS, 4800, frame capacity in words (160x120/4); pixels beyond it are discarded

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_sof  in  1  start-of-frame pulse from the camera stage
i_eof  in  1  end-of-frame pulse from the camera stage
i_dat  in  8  pixel byte
i_vld  in  1  i_dat valid, 1-cycle pulse per pixel
arm  in  1  request capture of the next frame (pulse)
abort  in  1  cancel capture (pulse)
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  write data
mem_we  out  1  write request
mem_ready  in  1  RAM accepts the write when mem_we&mem_ready
busy  out  1  high in any state other than IDLE
frame_done  out  1  1-cycle pulse when a frame is fully written
words_written  out  ADDR_W+1  words stored in the last completed frame
overflow  out  1  sticky: a word was dropped (FIFO full) or capacity exceeded; cleared on arm
checksum  out  32  see Optional Feature

Behaviour:
- Reset values: all outputs are 0; mem_addr=BASE_ADDR; state is IDLE; FIFO is empty; lane=0.
- States:
  - IDLE: on arm go to WAIT_SOF, and clear overflow.
  - WAIT_SOF: on i_sof go to CAPTURE, with lane=0, word count=0 and mem_addr=BASE_ADDR. i_vld/i_eof are ignored until i_sof.
  - CAPTURE: each i_vld writes i_dat into byte lane `lane` (lane0=bits[7:0]) and lane increments mod 4. When lane 3 is written, the assembled word is pushed to the FIFO in the next cycle.
    - On i_eof: if lane!=0, the partial word is zero-padded in the upper lanes and pushed. Then go to FLUSH.
    - If i_vld and i_eof occur in the same cycle, the byte is taken first, then eof is processed.
    - An i_sof seen in CAPTURE is ignored.
  - FLUSH: stays until the FIFO is empty and no write is outstanding. Then words_written is latched, frame_done pulses for 1 cycle, and the state goes to IDLE.
- arm in any state other than IDLE is ignored.
- abort in any state: go to IDLE on the next clock and empty the FIFO. mem_we drops the same cycle. No frame_done; words_written is unchanged. Abort has priority over all other events.
- Write port:
  - mem_we=1 whenever the FIFO is non-empty; mem_addr/mem_wdata show the FIFO head and stay stable while mem_we&~mem_ready.
  - On acceptance, the FIFO pops and mem_addr increments.
  - Minimum latency: 1 cycle from the 4th byte's i_vld to the FIFO push, then 1 cycle to mem_we.
- FIFO full: if a word completes while the FIFO holds 2 entries and no pop happens that cycle, the word is dropped and overflow is set. A simultaneous push and pop on a full FIFO succeeds.
- Capacity: once MAX_WORDS words have been pushed, further words are discarded and overflow is set. mem_addr never exceeds BASE_ADDR+MAX_WORDS-1.
- Word count: counts pushed words, saturating at MAX_WORDS. words_written holds the count of words actually accepted by the RAM.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined: checksum is a 32-bit mod-2^32 sum of every word accepted by the RAM during the frame. It clears on the WAIT_SOF to CAPTURE transition and is latched to the output on the frame_done cycle.
- Undefined: checksum is tied to 0 and there is no accumulator logic.

Test Plan:
- arm, sof, 8 bytes 0x01..0x08, eof with mem_ready=1 -> writes 0x04030201 @BASE and 0x08070605 @BASE+1; frame_done pulse; words_written=2; overflow=0.
- 6 bytes 0xA0..0xA5 then eof -> second word 0x0000A5A4; words_written=2.
- mem_ready held 0 for 20 cycles while 16 bytes stream at 1 byte per 4 clk -> 2 words buffered, the rest dropped; overflow=1; mem_addr/mem_wdata stable while stalled.
- MAX_WORDS=4 with 24 bytes -> exactly 4 writes at BASE..BASE+3; overflow=1; words_written=4.
- abort mid-CAPTURE -> mem_we=0 the next cycle, busy=0, no frame_done; a re-arm then captures the next frame from BASE.
- Pixels and eof with no arm, and a second sof during CAPTURE -> no writes for the unarmed frame; the second sof is ignored; with FRAME_CHECKSUM_EN on the 8-byte case, checksum=0x0C0A0806.
